// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : two-master round-robin arbiter/sequencer for one
// fixed-latency memory port. Optional grant lock: define MEM_ARB_LOCK_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 8,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic          r0_lock,
  input  logic          r1_lock,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] c_LAT = 3'(LAT);

  state_t          r_state;
  logic            r_ptr;
  logic [2:0]      r_cnt;
  logic            r_id;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_rvalid0;
  logic            r_rvalid1;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;

  logic            w_idle;
  logic            w_mask0;
  logic            w_mask1;
  logic            w_q0;
  logic            w_q1;
  logic            w_win;
  logic            w_gnt_any;
  logic            w_lock_sel;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

`ifdef MEM_ARB_LOCK_EN
  logic            r_lock_act;
  logic            r_lock_id;
  logic            w_hold_req;

  // The other master is only masked while the lock holder is still asking.
  assign w_hold_req = r_lock_id ? r1_req : r0_req;
  assign w_mask0    = r_lock_act &&  r_lock_id && r1_req;
  assign w_mask1    = r_lock_act && !r_lock_id && r0_req;
  assign w_lock_sel = w_win ? r1_lock : r0_lock;
`else
  assign w_mask0    = 1'b0;
  assign w_mask1    = 1'b0;
  assign w_lock_sel = 1'b0;
`endif

  assign w_idle      = (r_state == S_IDLE);
  assign w_q0        = r0_req && !w_mask0;
  assign w_q1        = r1_req && !w_mask1;
  assign w_win       = (w_q0 && w_q1) ? r_ptr : w_q1;
  assign w_gnt_any   = w_idle && (w_q0 || w_q1);
  assign w_sel_we    = w_win ? r1_we    : r0_we;
  assign w_sel_addr  = w_win ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_win ? r1_wdata : r0_wdata;

  assign r0_gnt    = w_gnt_any && !w_win;
  assign r1_gnt    = w_gnt_any &&  w_win;
  assign r0_rvalid = r_rvalid0;
  assign r1_rvalid = r_rvalid1;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = !w_idle;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_cnt       <= 3'd0;
      r_id        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
`ifdef MEM_ARB_LOCK_EN
      r_lock_act  <= 1'b0;
      r_lock_id   <= 1'b0;
`endif
    end else begin
      // Memory strobes and read-valid pulses are single-cycle by default.
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_state     <= S_ISSUE;
            r_id        <= w_win;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            if (!w_lock_sel) r_ptr <= ~w_win;
          end
        end
        S_ISSUE: begin
          if (r_mem_we) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= 3'd1;
          end
        end
        S_WAIT: begin
          if (r_cnt == c_LAT) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            if (r_id) begin
              r_rdata1  <= mem_rdata;
              r_rvalid1 <= 1'b1;
            end else begin
              r_rdata0  <= mem_rdata;
              r_rvalid0 <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef MEM_ARB_LOCK_EN
      if (w_idle) begin
        if (w_gnt_any) begin
          r_lock_act <= w_lock_sel;
          if (w_lock_sel) r_lock_id <= w_win;
        end else if (r_lock_act && !w_hold_req) begin
          r_lock_act <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed scenarios plus randomized traffic checked
// against a transaction-schedule model of the arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          r0_req = 1'b0, r0_we = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
  logic          r0_lock = 1'b0, r1_lock = 1'b0;
`endif
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory environment: contents start as addr ^ 0xB5; read data appears
  // exactly LAT cycles after the mem_en cycle, random junk otherwise.
  logic [DW-1:0] env_mem [256];
  logic          env_init = 1'b0;
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (!env_init) begin
      for (int a = 0; a < 256; a++) env_mem[a] <= 8'(a) ^ 8'hB5;
      env_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr] : 8'($urandom);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model: schedule of when the port is free, when the issue and
  // the read return happen, plus a shadow copy of the memory.
  logic [DW-1:0] ref_mem [256];
  logic          m_ptr = 1'b0, m_lock_act = 1'b0, m_lock_id = 1'b0;
  int            m_free = 0, m_iss_cyc = -1, m_rv_cyc = -1;
  logic          m_iss_we = 1'b0, m_rv_id = 1'b0;
  logic [AW-1:0] m_iss_addr = '0;
  logic [DW-1:0] m_iss_wdata = '0, m_rv_data = '0, m_rdata0 = '0, m_rdata1 = '0;
  logic          e_g0, e_g1, e_en, e_we, e_rv0, e_rv1, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd0, e_rd1;

  task automatic model_step();
    logic idle, q0, q1, w, lk, hreq;
    idle   = (cyc >= m_free);
    e_busy = !idle;
    e_rv0  = (m_rv_cyc == cyc) && !m_rv_id;
    e_rv1  = (m_rv_cyc == cyc) &&  m_rv_id;
    if (e_rv0) m_rdata0 = m_rv_data;
    if (e_rv1) m_rdata1 = m_rv_data;
    e_rd0  = m_rdata0;
    e_rd1  = m_rdata1;
    e_en   = (m_iss_cyc == cyc);
    e_we   = e_en && m_iss_we;
    e_addr = e_en ? m_iss_addr  : '0;
    e_wd   = e_en ? m_iss_wdata : '0;
    if (e_en) begin
      if (m_iss_we) ref_mem[m_iss_addr] = m_iss_wdata;
      else          m_rv_data = ref_mem[m_iss_addr];
    end
    hreq = m_lock_id ? r1_req : r0_req;
    if (m_lock_act && idle && !hreq) m_lock_act = 1'b0;
    q0   = r0_req && !(m_lock_act &&  m_lock_id);
    q1   = r1_req && !(m_lock_act && !m_lock_id);
    w    = (q0 && q1) ? m_ptr : q1;
    e_g0 = idle && q0 && !w;
    e_g1 = idle && q1 &&  w;
    if (e_g0 || e_g1) begin
      m_iss_cyc   = cyc + 1;
      m_iss_we    = w ? r1_we    : r0_we;
      m_iss_addr  = w ? r1_addr  : r0_addr;
      m_iss_wdata = w ? r1_wdata : r0_wdata;
      if (m_iss_we) m_free = cyc + 2;
      else begin
        m_free   = cyc + 2 + LAT;
        m_rv_cyc = cyc + 2 + LAT;
        m_rv_id  = w;
      end
      lk = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lk = w ? r1_lock : r0_lock;
`endif
      if (lk) begin m_lock_act = 1'b1; m_lock_id = w; end
      else    begin m_lock_act = 1'b0; m_ptr = !w;    end
    end
    if (!rst) begin
      m_ptr = 1'b0; m_lock_act = 1'b0; m_free = cyc + 1;
      m_iss_cyc = -1; m_rv_cyc = -1; m_rdata0 = '0; m_rdata1 = '0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    sample();
    advance();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    advance();
    for (int k = 0; k < 2; k++) begin
      sample();
      n_chk++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt got=%b%b want=00", r0_gnt, r1_gnt); end
      n_chk++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%b%b want=00", r0_rvalid, r1_rvalid); end
      n_chk++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_en_we got=%b%b want=00", mem_en, mem_we); end
      n_chk++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin n_err++; $display("FAIL rst_mem_bus got=%h/%h want=00/00", mem_addr, mem_wdata); end
      n_chk++; if (r0_rdata !== 8'h00 || r1_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata got=%h/%h want=00/00", r0_rdata, r1_rdata); end
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b want=0", busy); end
      advance();
    end
    rst = 1'b1;
  endtask

  task automatic test_read();
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
    for (int k = 0; k <= LAT + 2; k++) begin
      sample();
      if (k == 0) begin
        n_chk++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin n_err++; $display("FAIL read_gnt got=%b%b want=10", r0_gnt, r1_gnt); end
      end
      if (k == 1) begin
        n_chk++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL read_issue en/we got=%b%b want=10", mem_en, mem_we); end
        n_chk++; if (mem_addr !== 8'h10) begin n_err++; $display("FAIL read_addr got=%h want=10", mem_addr); end
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_busy got=%b want=1", busy); end
      end
      if (k >= 2 && k <= LAT + 1) begin
        n_chk++; if (mem_en !== 1'b0 || r0_rvalid !== 1'b0) begin n_err++; $display("FAIL read_wait k=%0d en/rvalid got=%b%b want=00", k, mem_en, r0_rvalid); end
      end
      if (k == LAT + 2) begin
        n_chk++; if (r0_rvalid !== 1'b1) begin n_err++; $display("FAIL read_rvalid got=%b want=1", r0_rvalid); end
        n_chk++; if (r0_rdata !== 8'hA5) begin n_err++; $display("FAIL read_rdata got=%h want=a5", r0_rdata); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_idle_busy got=%b want=0", busy); end
      end
      advance();
      if (k == 0) r0_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic exp0;
    logic [DW-1:0] exp_wd;
    do_reset();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h01; r0_wdata = 8'h11;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h02; r1_wdata = 8'h22;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (k % 2 == 0) begin
        exp0 = (k % 4 == 0);
        n_chk++; if (r0_gnt !== exp0 || r1_gnt !== !exp0) begin n_err++; $display("FAIL b2b_gnt k=%0d got=%b%b want=%b%b", k, r0_gnt, r1_gnt, exp0, !exp0); end
      end else begin
        exp_wd = (k % 4 == 1) ? 8'h11 : 8'h22;
        n_chk++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL b2b_en k=%0d got=%b%b want=11", k, mem_en, mem_we); end
        n_chk++; if (mem_wdata !== exp_wd) begin n_err++; $display("FAIL b2b_wdata k=%0d got=%h want=%h", k, mem_wdata, exp_wd); end
        n_chk++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin n_err++; $display("FAIL b2b_issue_gnt k=%0d got=%b%b want=00", k, r0_gnt, r1_gnt); end
      end
      advance();
    end
    r0_req = 1'b0; r1_req = 1'b0;
  endtask

  task automatic test_wait_block();
    do_reset();
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h40;
    for (int k = 0; k <= LAT + 2; k++) begin
      sample();
      if (k == 0) begin
        n_chk++; if (r1_gnt !== 1'b1) begin n_err++; $display("FAIL wb_r1_gnt got=%b want=1", r1_gnt); end
      end
      if (k >= 1 && k <= LAT + 1) begin
        n_chk++; if (r0_gnt !== 1'b0) begin n_err++; $display("FAIL wb_r0_early k=%0d got=%b want=0", k, r0_gnt); end
      end
      if (k == LAT + 2) begin
        n_chk++; if (r1_rvalid !== 1'b1 || r0_gnt !== 1'b1) begin n_err++; $display("FAIL wb_same_cycle rvalid1/gnt0 got=%b%b want=11", r1_rvalid, r0_gnt); end
        n_chk++; if (r1_rdata !== 8'hF5) begin n_err++; $display("FAIL wb_rdata got=%h want=f5", r1_rdata); end
      end
      advance();
      if (k == 0) begin
        r1_req = 1'b0;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h05; r0_wdata = 8'h55;
      end
    end
    r0_req = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h20;
    for (int k = 0; k <= LAT + 6; k++) begin
      rst = (k != 2);
      sample();
      if (k == 3) begin
        n_chk++; if (busy !== 1'b0 || mem_en !== 1'b0) begin n_err++; $display("FAIL mrst_state busy/en got=%b%b want=00", busy, mem_en); end
      end
      if (k >= 3) begin
        n_chk++; if (r0_rvalid !== 1'b0) begin n_err++; $display("FAIL mrst_rvalid k=%0d got=%b want=0", k, r0_rvalid); end
      end
      advance();
      if (k == 0) r0_req = 1'b0;
    end
    rst = 1'b1;
  endtask

  task automatic test_withdraw();
    do_reset();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h30; r1_wdata = 8'h66;
    for (int k = 0; k < 7; k++) begin
      sample();
      if (k == 0) begin
        n_chk++; if (r1_gnt !== 1'b1) begin n_err++; $display("FAIL wd_r1_gnt got=%b want=1", r1_gnt); end
      end
      if (k == 1) begin
        n_chk++; if (r0_gnt !== 1'b0) begin n_err++; $display("FAIL wd_gnt_in_issue got=%b want=0", r0_gnt); end
        n_chk++; if (mem_addr !== 8'h30 || mem_we !== 1'b1) begin n_err++; $display("FAIL wd_issue addr/we got=%h/%b want=30/1", mem_addr, mem_we); end
      end
      if (k >= 2) begin
        n_chk++; if (mem_en !== 1'b0 || r0_gnt !== 1'b0 || r0_rvalid !== 1'b0) begin n_err++; $display("FAIL wd_capture k=%0d en/gnt/rvalid got=%b%b%b want=000", k, mem_en, r0_gnt, r0_rvalid); end
      end
      advance();
      if (k == 0) begin r1_req = 1'b0; r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h77; end
      if (k == 1) r0_req = 1'b0;
    end
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    int order[$];
    int n0;
    n0 = 0;
    do_reset();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h03; r1_wdata = 8'h33;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h08; r0_lock = 1'b1;
    for (int k = 0; k < 80 && order.size() < 4; k++) begin
      sample();
      if (r0_gnt) begin order.push_back(0); n0++; end
      if (r1_gnt) order.push_back(1);
      advance();
      r0_lock = (n0 < 2);
      if (n0 >= 3) r0_req = 1'b0;
    end
    n_chk++; if (order.size() != 4) begin n_err++; $display("FAIL lock_count got=%0d want=4", order.size()); end
    foreach (order[i]) begin
      n_chk++; if (order[i] != ((i == 3) ? 1 : 0)) begin n_err++; $display("FAIL lock_order idx=%0d got=r%0d want=r%0d", i, order[i], (i == 3) ? 1 : 0); end
    end
    r1_req = 1'b0; r0_lock = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic g0, g1;
    g0 = 1'b0; g1 = 1'b0;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 63) != 0);
      if (g0) r0_req = 1'b0;
      else if (r0_req && $urandom_range(0, 7) == 0) r0_req = 1'b0;
      else if (!r0_req && $urandom_range(0, 2) == 0) begin
        r0_req = 1'b1; r0_we = 1'($urandom); r0_addr = 8'($urandom_range(0, 15)); r0_wdata = 8'($urandom);
      end
      if (g1) r1_req = 1'b0;
      else if (r1_req && $urandom_range(0, 7) == 0) r1_req = 1'b0;
      else if (!r1_req && $urandom_range(0, 2) == 0) begin
        r1_req = 1'b1; r1_we = 1'($urandom); r1_addr = 8'($urandom_range(0, 15)); r1_wdata = 8'($urandom);
      end
`ifdef MEM_ARB_LOCK_EN
      r0_lock = ($urandom_range(0, 3) == 0);
      r1_lock = ($urandom_range(0, 3) == 0);
`endif
      sample();
      g0 = r0_gnt; g1 = r1_gnt;
      n_chk++; if (r0_gnt !== e_g0) begin n_err++; $display("FAIL rnd_gnt0 cyc=%0d got=%b want=%b", cyc, r0_gnt, e_g0); end
      n_chk++; if (r1_gnt !== e_g1) begin n_err++; $display("FAIL rnd_gnt1 cyc=%0d got=%b want=%b", cyc, r1_gnt, e_g1); end
      n_chk++; if (mem_en !== e_en) begin n_err++; $display("FAIL rnd_mem_en cyc=%0d got=%b want=%b", cyc, mem_en, e_en); end
      n_chk++; if (mem_we !== e_we) begin n_err++; $display("FAIL rnd_mem_we cyc=%0d got=%b want=%b", cyc, mem_we, e_we); end
      n_chk++; if (mem_addr !== e_addr) begin n_err++; $display("FAIL rnd_mem_addr cyc=%0d got=%h want=%h", cyc, mem_addr, e_addr); end
      n_chk++; if (mem_wdata !== e_wd) begin n_err++; $display("FAIL rnd_mem_wdata cyc=%0d got=%h want=%h", cyc, mem_wdata, e_wd); end
      n_chk++; if (r0_rvalid !== e_rv0) begin n_err++; $display("FAIL rnd_rvalid0 cyc=%0d got=%b want=%b", cyc, r0_rvalid, e_rv0); end
      n_chk++; if (r1_rvalid !== e_rv1) begin n_err++; $display("FAIL rnd_rvalid1 cyc=%0d got=%b want=%b", cyc, r1_rvalid, e_rv1); end
      n_chk++; if (r0_rdata !== e_rd0) begin n_err++; $display("FAIL rnd_rdata0 cyc=%0d got=%h want=%h", cyc, r0_rdata, e_rd0); end
      n_chk++; if (r1_rdata !== e_rd1) begin n_err++; $display("FAIL rnd_rdata1 cyc=%0d got=%h want=%h", cyc, r1_rdata, e_rd1); end
      n_chk++; if (busy !== e_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, e_busy); end
      advance();
    end
    rst = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'hB5;
    test_reset();
    test_read();
    test_back_to_back();
    test_wait_block();
    test_reset_mid_read();
    test_withdraw();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for a single shared 1R1W-style memory port. It lets two processor-side masters share one memory port with a fixed read latency; the masters issue loads and stores like the `mem_r_*`/`mem_w_*` channels of the register-file processor. The block serialises accesses with round-robin fairness and drives the memory's enable, write-enable, address and data. It captures read data after the configured latency and returns it to the winning requester with a one-cycle valid pulse.

## Interface
Parameters:
- `AW`, 8, address width
- `DW`, 8, data width
- `LAT`, 1, memory read latency in cycles after the issue cycle; legal range 1..7

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `r0_req`  in  1  requester 0 request; held until `r0_gnt`
- `r0_we`  in  1  requester 0: 1 = write, 0 = read
- `r0_addr`  in  AW  requester 0 address
- `r0_wdata`  in  DW  requester 0 write data
- `r0_gnt`  out  1  requester 0 request accepted this cycle
- `r0_rvalid`  out  1  requester 0 read data valid, one-cycle pulse
- `r0_rdata`  out  DW  requester 0 read data
- `r1_*`  same seven ports for requester 1
- `r0_lock`, `r1_lock`  in  1  hold grant for the next access; present only with `MEM_ARB_LOCK_EN`
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid exactly `LAT` cycles after the `mem_en` cycle
- `busy`  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: a grant is possible.
  - ISSUE: `mem_en`=1 for exactly one cycle, driven from the captured request.
  - WAIT: reads only; a counter runs 1..`LAT`.
- Grant logic:
  - `rX_gnt` is combinational and equals IDLE && `rX_req` && winner==X.
  - On the `gnt` cycle the arbiter captures `we`, `addr`, `wdata` and requester id, and the next state is ISSUE.
- Arbitration:
  - Round-robin with a 1-bit priority pointer; reset value 0 (r0 favoured).
  - With a single requester, that requester wins.
  - With both requesting, the pointer's requester wins and the pointer moves to the other requester after every grant.
- Write path: ISSUE → IDLE. No `rvalid` is generated for writes.
- Read path:
  - ISSUE → WAIT. The counter loads 1 and increments each cycle in WAIT.
  - In the WAIT cycle where the counter equals `LAT`, `mem_rdata` is registered into the winner's `rdata` register and the next state is IDLE.
  - The winner's `rvalid` is 1 in the following cycle, which is already IDLE.
- `rX_rdata` holds its last captured value until the next read completes for that requester.
- The `mem_*` outputs are 0 whenever `mem_en`=0; `mem_addr` and `mem_wdata` are 0 outside ISSUE.
- Simultaneous `rvalid` and new `gnt` in the same IDLE cycle is legal and required.
- Dropping `req` before `gnt` withdraws the request cleanly; no capture occurs.

## Timing
- Reset (`rst`=0 at an edge) forces:
  - state IDLE, pointer 0, counter 0
  - all `gnt`, `rvalid`, `mem_en`, `mem_we` = 0
  - all `rdata`, `mem_addr`, `mem_wdata` = 0
- Reset mid-read discards the in-flight access; no `rvalid` follows.
- Read latency: from `gnt` at cycle t, `mem_en` at t+1, sample at t+1+`LAT`, `rvalid` at t+2+`LAT`.
  - Next grant possible at t+2+`LAT`.
  - Throughput: one read per `LAT`+2 cycles.
- Write: `gnt` at t, `mem_en`/`mem_we` at t+1, next grant at t+2.
- `gnt` is never asserted outside IDLE; a requester waiting during ISSUE/WAIT keeps `req` high.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - The `rX_lock` ports exist.
  - If `rX_lock`=1 on the `gnt` cycle, the pointer does not move, and in the next IDLE the other requester is masked.
  - The lock releases on the first grant to the holder with `lock`=0, or when the holder is in IDLE with `req`=0.
  - Reset clears the lock.
- Undefined: no lock ports, pure round-robin as above.

## Test plan
- Reset, then `r0_req` read addr 0x10, `LAT`=1, `mem_rdata`=0xA5 at sample cycle → `r0_gnt` at t, `mem_en`=1/`mem_we`=0/`mem_addr`=0x10 at t+1, `r0_rvalid`=1 with `r0_rdata`=0xA5 at t+3.
- Both requesters hold write requests continuously (r0: 0x01←0x11, r1: 0x02←0x22) → grants alternate r0, r1, r0, ... every 2 cycles; `mem_wdata` alternates 0x11/0x22.
- `LAT`=3, r1 read addr 0x40, r0 requests during WAIT → `r0_gnt` stays low until `r1_rvalid` cycle (t+5), where `r0_gnt`=1 in the same cycle.
- Assert `rst`=0 in the WAIT cycle of a read → next cycle state IDLE, `busy`=0, and no `rvalid` for that read ever appears.
- `MEM_ARB_LOCK_EN`: r0 issues three reads with `r0_lock`=1,1,0 while r1 requests continuously → r0 receives three consecutive grants, then r1 is granted.
- `req` pulsed one cycle while the other requester is in ISSUE → no capture and no `mem_en` for the withdrawn request.
